// File: rtl/sll_req_arbiter_if.sv
// Requester-side and engine-side signals of the shared linked-list arbiter.
// The arbiter connects through the slave modport; the requester/engine side uses master.
interface sll_req_arbiter_if #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MAX_NODE   = 8
);
    localparam int unsigned ADDR_WIDTH = $clog2(MAX_NODE + 1);
    localparam int unsigned ID_WIDTH   = $clog2(NUM_REQ);
    localparam int unsigned OP_WIDTH   = 3;

    logic [NUM_REQ-1:0]            req_valid;
    logic [OP_WIDTH*NUM_REQ-1:0]   req_op;
    logic [ADDR_WIDTH*NUM_REQ-1:0] req_addr;
    logic [DATA_WIDTH*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]            resp_done;
    logic [DATA_WIDTH-1:0]         resp_data;
    logic [ADDR_WIDTH-1:0]         resp_next_addr;
    logic                          resp_fault;
    logic                          ll_op_start;
    logic [OP_WIDTH-1:0]           ll_op;
    logic [ADDR_WIDTH-1:0]         ll_addr_in;
    logic [DATA_WIDTH-1:0]         ll_data_in;
    logic                          ll_op_done;
    logic [DATA_WIDTH-1:0]         ll_data_out;
    logic [ADDR_WIDTH-1:0]         ll_next_node_addr;
    logic                          ll_fault;
    logic                          busy;
    logic [ID_WIDTH-1:0]           grant_id;

    modport slave (
        input  req_valid, req_op, req_addr, req_data,
               ll_op_done, ll_data_out, ll_next_node_addr, ll_fault,
        output resp_done, resp_data, resp_next_addr, resp_fault,
               ll_op_start, ll_op, ll_addr_in, ll_data_in, busy, grant_id
    );

    modport master (
        output req_valid, req_op, req_addr, req_data,
               ll_op_done, ll_data_out, ll_next_node_addr, ll_fault,
        input  resp_done, resp_data, resp_next_addr, resp_fault,
               ll_op_start, ll_op, ll_addr_in, ll_data_in, busy, grant_id
    );
endinterface

// File: rtl/sll_req_arbiter.sv
// Round-robin arbiter that time-shares one singly-linked-list engine among NUM_REQ requesters,
// holding the engine request stable until op_done and returning the result as a one-hot pulse.
module sll_req_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MAX_NODE   = 8
) (
    input  logic             clk,
    input  logic             rst,
    sll_req_arbiter_if.slave arb_io
);
    localparam int unsigned ADDR_WIDTH = $clog2(MAX_NODE + 1);
    localparam int unsigned ID_WIDTH   = $clog2(NUM_REQ);
    localparam int unsigned IDW1       = ID_WIDTH + 1;
    localparam int unsigned OP_WIDTH   = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_REJECT = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    state_e                 state_q, state_d;
    logic [ID_WIDTH-1:0]    rr_ptr_q, rr_ptr_d;
    logic [ID_WIDTH-1:0]    grant_id_q, grant_id_d;
    logic [OP_WIDTH-1:0]    op_q, op_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [DATA_WIDTH-1:0]  data_q, data_d;
    logic                   op_start_q, op_start_d;
    logic [NUM_REQ-1:0]     resp_done_q, resp_done_d;
    logic [DATA_WIDTH-1:0]  resp_data_q, resp_data_d;
    logic [ADDR_WIDTH-1:0]  resp_next_q, resp_next_d;
    logic                   resp_fault_q, resp_fault_d;
    logic                   busy_q, busy_d;

    logic                   found;
    logic [ID_WIDTH-1:0]    sel;
    logic [IDW1-1:0]        cand_w;

    logic [OP_WIDTH-1:0]    req_op_arr   [NUM_REQ];
    logic [ADDR_WIDTH-1:0]  req_addr_arr [NUM_REQ];
    logic [DATA_WIDTH-1:0]  req_data_arr [NUM_REQ];

    // Unpack the flat per-requester payload buses.
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign req_op_arr[g]   = arb_io.req_op[OP_WIDTH*g +: OP_WIDTH];
        assign req_addr_arr[g] = arb_io.req_addr[ADDR_WIDTH*g +: ADDR_WIDTH];
        assign req_data_arr[g] = arb_io.req_data[DATA_WIDTH*g +: DATA_WIDTH];
    end

    function automatic logic op_is_legal(input logic [OP_WIDTH-1:0] op);
        return !(op == 3'd4 || op == 3'd6);
    endfunction

    always_ff @(posedge clk or posedge rst) begin : p_regs
        if (rst) begin
            state_q      <= ST_IDLE;
            rr_ptr_q     <= '0;
            grant_id_q   <= '0;
            op_q         <= '0;
            addr_q       <= '0;
            data_q       <= '0;
            op_start_q   <= 1'b0;
            resp_done_q  <= '0;
            resp_data_q  <= '0;
            resp_next_q  <= '0;
            resp_fault_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            grant_id_q   <= grant_id_d;
            op_q         <= op_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            op_start_q   <= op_start_d;
            resp_done_q  <= resp_done_d;
            resp_data_q  <= resp_data_d;
            resp_next_q  <= resp_next_d;
            resp_fault_q <= resp_fault_d;
            busy_q       <= busy_d;
        end
    end

    always_comb begin : p_next
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        grant_id_d   = grant_id_q;
        op_d         = op_q;
        addr_d       = addr_q;
        data_d       = data_q;
        op_start_d   = op_start_q;
        resp_done_d  = '0;
        resp_data_d  = resp_data_q;
        resp_next_d  = resp_next_q;
        resp_fault_d = resp_fault_q;
        found        = 1'b0;
        sel          = '0;
        cand_w       = '0;

        // First pending requester at or after rr_ptr, wrapping modulo NUM_REQ.
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            cand_w = {1'b0, rr_ptr_q} + IDW1'(k);
            if (cand_w >= IDW1'(NUM_REQ)) begin
                cand_w = cand_w - IDW1'(NUM_REQ);
            end
            if (!found && arb_io.req_valid[cand_w[ID_WIDTH-1:0]]) begin
                found = 1'b1;
                sel   = cand_w[ID_WIDTH-1:0];
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    grant_id_d = sel;
                    op_d       = req_op_arr[sel];
                    addr_d     = req_addr_arr[sel];
                    data_d     = req_data_arr[sel];
                    if (op_is_legal(req_op_arr[sel])) begin
                        state_d    = ST_ISSUE;
                        op_start_d = 1'b1;
                    end else begin
                        state_d = ST_REJECT;
                    end
                end
            end
            ST_ISSUE: begin
                if (arb_io.ll_op_done) begin
                    resp_data_d  = arb_io.ll_data_out;
                    resp_next_d  = arb_io.ll_next_node_addr;
                    resp_fault_d = arb_io.ll_fault;
                    resp_done_d  = NUM_REQ'(1) << grant_id_q;
                    op_start_d   = 1'b0;
                    state_d      = ST_RESP;
                end
            end
            ST_REJECT: begin
                resp_data_d  = '0;
                resp_next_d  = '0;
                resp_fault_d = 1'b1;
                resp_done_d  = NUM_REQ'(1) << grant_id_q;
                state_d      = ST_RESP;
            end
            ST_RESP: begin
                rr_ptr_d = (grant_id_q == ID_WIDTH'(NUM_REQ - 1)) ? '0
                                                                  : grant_id_q + ID_WIDTH'(1);
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    assign arb_io.resp_done      = resp_done_q;
    assign arb_io.resp_data      = resp_data_q;
    assign arb_io.resp_next_addr = resp_next_q;
    assign arb_io.resp_fault     = resp_fault_q;
    assign arb_io.ll_op_start    = op_start_q;
    assign arb_io.ll_op          = op_q;
    assign arb_io.ll_addr_in     = addr_q;
    assign arb_io.ll_data_in     = data_q;
    assign arb_io.busy           = busy_q;
    assign arb_io.grant_id       = grant_id_q;

endmodule
